// File: rtl/lcd_fifo_unpacker_if.sv
// FIFO-read and pixel-stream signals of the LCD FIFO unpacker.
// master: the unpacker side; slave: FIFO plus downstream serializer.
interface lcd_fifo_unpacker_if #(
  parameter int DW = 32,
  parameter int PW = 16
);
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_pull;
  logic          pix_valid;
  logic          pix_ready;
  logic [PW-1:0] pix_data;

  modport master (
    input  fifo_data, fifo_empty, pix_ready,
    output fifo_pull, pix_valid, pix_data
  );

  modport slave (
    output fifo_data, fifo_empty, pix_ready,
    input  fifo_pull, pix_valid, pix_data
  );
endinterface

// File: rtl/lcd_fifo_unpacker.sv
// LCD FIFO unpacker: pops 32-bit words from a first-word-fall-through
// FIFO and streams them out as 1/2/4/8/16-bit pixels, LSB pixel first.
// A frame pulse flushes the current word and clears the per-frame
// underflow counter.
module lcd_fifo_unpacker #(
  parameter int DW  = 32,
  parameter int PW  = 16,
  parameter int UCW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lcd_fifo_unpacker_if.master    bus,
  input  logic [2:0]             bpp,
  input  logic                   fp_pulse,
  output logic                   underflow,
  output logic [UCW-1:0]         underflow_cnt
);

  typedef enum logic [2:0] {
    BPP1  = 3'd0,
    BPP2  = 3'd1,
    BPP4  = 3'd2,
    BPP8  = 3'd3,
    BPP16 = 3'd4
  } bpp_e;

  // Codes 5..7 behave as 16 bpp.
  function automatic bpp_e norm_bpp(input logic [2:0] code);
    case (code)
      3'd0:    return BPP1;
      3'd1:    return BPP2;
      3'd2:    return BPP4;
      3'd3:    return BPP8;
      default: return BPP16;
    endcase
  endfunction

  function automatic int unsigned px_bits(input bpp_e b);
    case (b)
      BPP1:    return 1;
      BPP2:    return 2;
      BPP4:    return 4;
      BPP8:    return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [5:0] px_per_word(input bpp_e b);
    case (b)
      BPP1:    return 6'd32;
      BPP2:    return 6'd16;
      BPP4:    return 6'd8;
      BPP8:    return 6'd4;
      default: return 6'd2;
    endcase
  endfunction

  function automatic logic [PW-1:0] px_mask(input bpp_e b);
    return PW'((32'd1 << px_bits(b)) - 32'd1);
  endfunction

  logic [DW-1:0] word_reg;
  logic          word_vld;
  logic [5:0]    pix_left;
  bpp_e          bpp_lat;
  logic          accept;
  logic          last_px;
  logic          load;

  assign accept  = word_vld & bus.pix_ready;
  assign last_px = (pix_left == 6'd1);
  // Pull is held off during reset so the FIFO never loses a word the
  // unpacker is not able to capture.
  assign load    = rst_n & ~bus.fifo_empty & ~fp_pulse &
                   (~word_vld | (accept & last_px));

  assign bus.fifo_pull = load;
  assign bus.pix_valid = word_vld;
  assign bus.pix_data  = word_reg[PW-1:0] & px_mask(bpp_lat);

  // Word register, pixel countdown and latched pixel format.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= '0;
      word_vld <= 1'b0;
      pix_left <= '0;
      bpp_lat  <= BPP16;
    end else if (fp_pulse) begin
      word_vld <= 1'b0;
      pix_left <= '0;
    end else if (load) begin
      word_reg <= bus.fifo_data;
      pix_left <= px_per_word(norm_bpp(bpp));
      bpp_lat  <= norm_bpp(bpp);
      word_vld <= 1'b1;
    end else if (accept) begin
      word_reg <= word_reg >> px_bits(bpp_lat);
      pix_left <= pix_left - 6'd1;
      if (last_px) begin
        word_vld <= 1'b0;
      end
    end
  end

  // Underflow pulse and saturating per-frame count; frame clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      underflow <= bus.pix_ready & ~word_vld;
      if (fp_pulse) begin
        underflow_cnt <= '0;
      end else if (bus.pix_ready & ~word_vld & (underflow_cnt != '1)) begin
        underflow_cnt <= underflow_cnt + 1'b1;
      end
    end
  end

  a_no_pull_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.fifo_pull && bus.fifo_empty));

  a_hold_until_accept : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.pix_valid && !bus.pix_ready && !fp_pulse) |=>
      (bus.pix_valid && $stable(bus.pix_data)));

  a_pix_left_range : assert property (@(posedge clk) disable iff (!rst_n)
    pix_left <= 6'd32);

endmodule

// File: tb/tb_lcd_fifo_unpacker.sv
// Bench for lcd_fifo_unpacker: FIFO modelled as a word queue, expected
// pixels kept as a queue of unpacked values for the word in flight.
module tb_lcd_fifo_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  bpp;
  logic        fp_pulse;
  logic        underflow;
  logic [15:0] underflow_cnt;

  lcd_fifo_unpacker_if #(.DW(32), .PW(16)) bif ();

  lcd_fifo_unpacker #(.DW(32), .PW(16), .UCW(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bif),
    .bpp           (bpp),
    .fp_pulse      (fp_pulse),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  logic [15:0] mq[$];
  logic        m_uf;
  logic [15:0] m_cnt;
  logic        m_pull;
  logic        dut_pull;
  logic [2:0]  cur_b;
  logic        cur_r;
  logic        cur_f;
  logic        cur_empty;
  logic [31:0] cur_word;

  typedef struct {
    logic        rst;
    logic        push;
    logic [31:0] word;
    logic [2:0]  bpp;
    logic        ready;
    logic        fp;
    logic        exp_pull;
    logic        exp_valid;
    logic [15:0] exp_data;
  } tv_t;

  tv_t tv[18];

  function automatic tv_t mk(input logic rs, input logic ps, input logic [31:0] w,
                             input logic [2:0] b, input logic r, input logic f,
                             input logic ep, input logic ev, input logic [15:0] ed);
    tv_t t;
    t.rst = rs; t.push = ps; t.word = w; t.bpp = b; t.ready = r; t.fp = f;
    t.exp_pull = ep; t.exp_valid = ev; t.exp_data = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Split a word into its pixels, lowest bits first.
  task automatic unpack(input logic [31:0] word, input logic [2:0] b);
    int unsigned w;
    longint unsigned wd;
    w  = (b >= 3'd4) ? 16 : (1 << b);
    wd = longint'(word);
    for (int unsigned i = 0; i < 32 / w; i++)
      mq.push_back(16'((wd >> (i * w)) & ((64'd1 << w) - 64'd1)));
  endtask

  // Called at a falling edge: apply inputs and compare against the model.
  task automatic drive(input logic [2:0] b, input logic r, input logic f);
    bpp = b;
    fp_pulse = f;
    bif.pix_ready = r;
    bif.fifo_empty = (q.size() == 0);
    if (q.size() != 0) bif.fifo_data = q[0];
    else bif.fifo_data = 32'hDEAD_BEEF;
    cur_b = b; cur_r = r; cur_f = f;
    cur_empty = bif.fifo_empty; cur_word = bif.fifo_data;
    m_pull = !cur_empty && !f && (mq.size() == 0 || (r && mq.size() == 1));
    #1;
    dut_pull = bif.fifo_pull;
    chk("pull", dut_pull, m_pull);
    chk("valid", bif.pix_valid, mq.size() != 0);
    if (mq.size() != 0) chk("data", bif.pix_data, mq[0]);
    chk("underflow", underflow, m_uf);
    chk("ucnt", underflow_cnt, m_cnt);
  endtask

  // Cross the rising edge, update FIFO and model, return at falling edge.
  task automatic advance();
    logic had;
    @(posedge clk);
    if (dut_pull && q.size() != 0) void'(q.pop_front());
    had  = (mq.size() != 0);
    m_uf = cur_r && !had;
    if (cur_f) m_cnt = 16'h0;
    else if (cur_r && !had && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
    if (cur_f) mq.delete();
    else begin
      if (cur_r && had) void'(mq.pop_front());
      if (m_pull) unpack(cur_word, cur_b);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fp_pulse = 1'b0;
    bif.pix_ready = 1'b1;
    bif.fifo_empty = (q.size() == 0);
    if (q.size() != 0) bif.fifo_data = q[0];
    #1;
    chk("rst_valid", bif.pix_valid, 1'b0);
    chk("rst_data", bif.pix_data, 16'h0);
    chk("rst_pull", bif.fifo_pull, 1'b0);
    chk("rst_uf", underflow, 1'b0);
    chk("rst_cnt", underflow_cnt, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_uf = 1'b0;
    m_cnt = 16'h0;
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; bpp = 3'd0; fp_pulse = 1'b0;
    bif.pix_ready = 1'b0; bif.fifo_empty = 1'b1; bif.fifo_data = '0;
    m_uf = 1'b0; m_cnt = 16'h0;

    // 8 bpp single word
    tv[0]  = mk(1, 1, 32'h44332211, 3, 1, 0, 1, 0, 16'h0000);
    tv[1]  = mk(0, 0, 32'h0,        3, 1, 0, 0, 1, 16'h0011);
    tv[2]  = mk(0, 0, 32'h0,        3, 1, 0, 0, 1, 16'h0022);
    tv[3]  = mk(0, 0, 32'h0,        3, 1, 0, 0, 1, 16'h0033);
    tv[4]  = mk(0, 0, 32'h0,        3, 1, 0, 0, 1, 16'h0044);
    tv[5]  = mk(0, 0, 32'h0,        3, 1, 0, 0, 0, 16'h0000);
    // 16 bpp back-to-back words
    tv[6]  = mk(1, 1, 32'hBBBBAAAA, 4, 1, 0, 1, 0, 16'h0000);
    tv[7]  = mk(0, 1, 32'hDDDDCCCC, 4, 1, 0, 0, 1, 16'hAAAA);
    tv[8]  = mk(0, 0, 32'h0,        4, 1, 0, 1, 1, 16'hBBBB);
    tv[9]  = mk(0, 0, 32'h0,        4, 1, 0, 0, 1, 16'hCCCC);
    tv[10] = mk(0, 0, 32'h0,        4, 1, 0, 0, 1, 16'hDDDD);
    tv[11] = mk(0, 0, 32'h0,        4, 1, 0, 0, 0, 16'h0000);
    // frame pulse after two of four pixels
    tv[12] = mk(1, 1, 32'hDDCCBBAA, 3, 1, 0, 1, 0, 16'h0000);
    tv[13] = mk(0, 0, 32'h0,        3, 1, 0, 0, 1, 16'h00AA);
    tv[14] = mk(0, 0, 32'h0,        3, 1, 0, 0, 1, 16'h00BB);
    tv[15] = mk(0, 1, 32'h12345678, 3, 1, 1, 0, 1, 16'h00CC);
    tv[16] = mk(0, 0, 32'h0,        3, 0, 0, 1, 0, 16'h0000);
    tv[17] = mk(0, 0, 32'h0,        3, 1, 0, 0, 1, 16'h0078);

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      if (tv[i].rst) q.delete();
      if (tv[i].push) q.push_back(tv[i].word);
      if (tv[i].rst) do_reset();
      drive(tv[i].bpp, tv[i].ready, tv[i].fp);
      chk($sformatf("tv%0d_pull", i), bif.fifo_pull, tv[i].exp_pull);
      chk($sformatf("tv%0d_valid", i), bif.pix_valid, tv[i].exp_valid);
      if (tv[i].exp_valid) chk($sformatf("tv%0d_data", i), bif.pix_data, tv[i].exp_data);
      advance();
    end

    // 1 bpp: 32 pixels from a single word, reset lands mid-word first
    q.delete(); q.push_back(32'h0000_0005);
    do_reset();
    drive(3'd0, 1'b1, 1'b0);
    chk("s3_load_pull", bif.fifo_pull, 1'b1);
    advance();
    for (int i = 0; i < 32; i++) begin
      drive(3'd0, 1'b1, 1'b0);
      chk($sformatf("s3_valid%0d", i), bif.pix_valid, 1'b1);
      chk($sformatf("s3_px%0d", i), bif.pix_data, (i == 0 || i == 2) ? 16'h1 : 16'h0);
      chk($sformatf("s3_pull%0d", i), bif.fifo_pull, 1'b0);
      advance();
    end
    drive(3'd0, 1'b1, 1'b0);
    chk("s3_end_valid", bif.pix_valid, 1'b0);
    chk("s3_end_pull", bif.fifo_pull, 1'b0);
    advance();

    // 4 bpp with pix_ready toggling: each pixel held while not accepted
    q.push_back(32'h87654321);
    do_reset();
    drive(3'd2, 1'b0, 1'b0);
    advance();
    for (int k = 0; k < 15; k++) begin
      drive(3'd2, (k % 2) == 0, 1'b0);
      chk($sformatf("s4_valid%0d", k), bif.pix_valid, 1'b1);
      chk($sformatf("s4_px%0d", k), bif.pix_data, 16'((k + 1) / 2 + 1));
      advance();
    end
    drive(3'd2, 1'b0, 1'b0);
    chk("s4_end_valid", bif.pix_valid, 1'b0);
    advance();

    // Underflow pulses, frame clear, saturation
    q.delete();
    do_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive(3'd3, i < 5, 1'b0);
      if (underflow === 1'b1) pulses++;
      advance();
    end
    chk("s6_pulses", pulses, 5);
    drive(3'd3, 1'b0, 1'b1);
    chk("s6_cnt5", underflow_cnt, 16'd5);
    advance();
    drive(3'd3, 1'b0, 1'b0);
    chk("s6_cleared", underflow_cnt, 16'd0);
    advance();
    for (int i = 0; i < 70000; i++) begin
      drive(3'd3, 1'b1, 1'b0);
      advance();
    end
    drive(3'd3, 1'b0, 1'b0);
    chk("s6_saturated", underflow_cnt, 16'hFFFF);
    advance();

    // Random traffic against the model, with a reset in the middle
    q.delete();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) do_reset();
      if ($urandom_range(0, 2) != 0 && q.size() < 4) q.push_back($urandom());
      drive(3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 60) == 0);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
